// File: rtl/dmem_pkg.sv
// Shared types and sizes for the block-granular data memory.
package dmem_pkg;

  localparam int unsigned BLOCK_WIDTH     = 128;
  localparam int unsigned WORDS_PER_BLOCK = 4;
  localparam int unsigned COUNT_W         = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_block_array.sv
// Block storage: synchronous write and synchronous registered read.
// Only the read-data register is reset; the array contents survive reset.
module dmem_block_array
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   we_i,
  input  logic                   re_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [BLOCK_WIDTH-1:0] wdata_i,
  output logic [BLOCK_WIDTH-1:0] rdata_o
);

  logic [BLOCK_WIDTH-1:0] mem_q [2**ADDR_W];
  logic [BLOCK_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read data is held until the next read completes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory.sv
// Fixed-latency 128-bit block memory behind the data-cache controller.
// A request is latched in IDLE, counted down in BUSY and completed into DONE.
module data_memory
  import dmem_pkg::*;
#(
  parameter int unsigned BLOCK_ADDR_W = 8,
  parameter int unsigned LATENCY      = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [BLOCK_ADDR_W-1:0] mem_address,
  input  logic [BLOCK_WIDTH-1:0]  mem_writedata,
  output logic [BLOCK_WIDTH-1:0]  mem_readdata,
  output logic                    mem_busywait
);

  dmem_state_e             state_q;
  logic [COUNT_W-1:0]      count_q;
  logic                    wr_q;
  logic [BLOCK_ADDR_W-1:0] addr_q;
  logic [BLOCK_WIDTH-1:0]  wdata_q;

  logic complete_c;
  logic we_c;
  logic re_c;

  // Request latches, countdown and state sequencing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_read || mem_write) begin
            state_q <= BUSY;
            count_q <= COUNT_W'(LATENCY - 1);
            wr_q    <= mem_write;
            addr_q  <= mem_address;
            wdata_q <= mem_writedata;
          end
        end
        BUSY: begin
          if (count_q == '0) begin
            state_q <= DONE;
          end else begin
            count_q <= count_q - COUNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Busywait is combinational in IDLE so the requester stalls immediately.
  always_comb begin
    complete_c   = 1'b0;
    we_c         = 1'b0;
    re_c         = 1'b0;
    mem_busywait = 1'b0;
    case (state_q)
      IDLE: mem_busywait = mem_read | mem_write;
      BUSY: begin
        mem_busywait = 1'b1;
        complete_c   = (count_q == '0);
      end
      default: mem_busywait = 1'b0;
    endcase
    we_c = complete_c & wr_q;
    re_c = complete_c & ~wr_q;
  end

  dmem_block_array #(
    .ADDR_W (BLOCK_ADDR_W)
  ) u_array (
    .clk_i   (clock),
    .rst_i   (reset),
    .we_i    (we_c),
    .re_i    (re_c),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (mem_readdata)
  );

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed table, corner sequences, random ops.
module tb_data_memory;

  localparam int unsigned LAT = 5;

  logic         clock;
  logic         reset;
  logic         mem_read;
  logic         mem_write;
  logic [7:0]   mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  data_memory #(.BLOCK_ADDR_W(8), .LATENCY(LAT)) dut (
    .clock         (clock),
    .reset         (reset),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: block contents, which blocks are known, last read data.
  logic [127:0] mdl [256];
  bit           vld [256];
  logic [127:0] last_rd = '0;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [7:0]   addr;
    logic [127:0] data;
    int           chg_cyc;
    logic [7:0]   chg_addr;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl [10];

  localparam logic [127:0] D12  = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] D05  = 128'h05050505_15151515_25252525_35353535;
  localparam logic [127:0] D06  = 128'h06060606_16161616_26262626_36363636;
  localparam logic [127:0] DDB  = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [127:0] D30  = 128'h30303030_CAFEF00D_30303030_12345678;
  localparam logic [127:0] D00  = 128'h00000001_00000002_00000003_00000004;
  localparam logic [127:0] DFF  = 128'hFFFF0000_0000FFFF_F0F0F0F0_0F0F0F0F;
  localparam logic [127:0] DAA  = {16{8'hAA}};

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic model_apply(input logic rd, input logic wr, input logic [7:0] addr,
                             input logic [127:0] data, output logic [127:0] exp);
    if (wr) begin
      mdl[addr] = data;
      vld[addr] = 1'b1;
    end else if (rd) begin
      last_rd = mdl[addr];
    end
    exp = last_rd;
  endtask

  // Issue one request from IDLE (called at a negedge) and follow it to DONE.
  task automatic run_access(input string nm, input logic rd, input logic wr,
                            input logic [7:0] addr, input logic [127:0] data,
                            input int chg_cyc, input logic [7:0] chg_addr,
                            input bit drop, input logic [7:0] nxt_addr,
                            output logic [127:0] got, output int busy);
    int cyc;
    bit done;
    mem_read      = rd;
    mem_write     = wr;
    mem_address   = addr;
    mem_writedata = data;
    #1;
    chk({nm, "_busy_rise"}, 128'(mem_busywait), 128'(1));
    busy = 1;
    cyc  = 0;
    done = 1'b0;
    while (!done) begin
      @(posedge clock);
      @(negedge clock);
      cyc++;
      if (cyc == chg_cyc) mem_address = chg_addr;
      if (!mem_busywait) begin
        done = 1'b1;
      end else begin
        busy++;
        if (cyc > 40) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s_timeout: busywait still high after %0d cycles, required low by %0d",
                   nm, cyc, LAT + 1);
          done = 1'b1;
        end
      end
    end
    got = mem_readdata;
    if (drop) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end else begin
      mem_address = nxt_addr;
    end
    @(posedge clock);
    @(negedge clock);
    if (drop) begin
      chk({nm, "_idle"}, 128'(mem_busywait), 128'(0));
    end else begin
      chk({nm, "_reaccept"}, 128'(mem_busywait), 128'(1));
      chk({nm, "_hold"}, mem_readdata, got);
    end
  endtask

  initial begin
    logic [127:0] got;
    logic [127:0] exp;
    logic [127:0] rdata;
    logic [7:0]   a;
    int           busy;
    int           op;
    int           tries;

    tbl[0] = '{1'b0, 1'b1, 8'h12, D12, 0, 8'h00, 128'h0};
    tbl[1] = '{1'b1, 1'b0, 8'h12, '0,  0, 8'h00, D12};
    tbl[2] = '{1'b0, 1'b1, 8'h05, D05, 0, 8'h00, D12};
    tbl[3] = '{1'b0, 1'b1, 8'h06, D06, 0, 8'h00, D12};
    tbl[4] = '{1'b1, 1'b0, 8'h05, '0,  2, 8'h06, D05};
    tbl[5] = '{1'b1, 1'b1, 8'h20, DDB, 0, 8'h00, D05};
    tbl[6] = '{1'b1, 1'b0, 8'h20, '0,  0, 8'h00, DDB};
    tbl[7] = '{1'b0, 1'b1, 8'h30, D30, 0, 8'h00, DDB};
    tbl[8] = '{1'b0, 1'b1, 8'h00, D00, 0, 8'h00, DDB};
    tbl[9] = '{1'b0, 1'b1, 8'hFF, DFF, 0, 8'h00, DDB};

    reset = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_address = '0;
    mem_writedata = '0;
    repeat (2) @(negedge clock);
    chk("rst_readdata", mem_readdata, '0);
    chk("rst_busywait", 128'(mem_busywait), 128'(0));
    reset = 1'b0;
    @(negedge clock);
    chk("idle_readdata", mem_readdata, '0);
    chk("idle_busywait", 128'(mem_busywait), 128'(0));

    // Directed table
    for (int i = 0; i < 10; i++) begin
      run_access($sformatf("tbl%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data,
                 tbl[i].chg_cyc, tbl[i].chg_addr, 1'b1, 8'h00, got, busy);
      model_apply(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, exp);
      chk($sformatf("tbl%0d_data", i), got, tbl[i].exp);
      chk($sformatf("tbl%0d_busy_cycles", i), 128'(busy), 128'(LAT + 1));
    end

    // Reset mid-write to block 0x30 at count 2: write is aborted
    mem_write = 1'b1;
    mem_address = 8'h30;
    mem_writedata = DAA;
    #1;
    chk("abort_busy_rise", 128'(mem_busywait), 128'(1));
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort_busy_follows_req", 128'(mem_busywait), 128'(1));
    chk("abort_readdata_zero", mem_readdata, '0);
    mem_write = 1'b0;
    #1;
    chk("abort_busy_no_req", 128'(mem_busywait), 128'(0));
    @(negedge clock);
    reset = 1'b0;
    last_rd = '0;
    #1;
    chk("abort_idle_busywait", 128'(mem_busywait), 128'(0));
    run_access("abort_read30", 1'b1, 1'b0, 8'h30, '0, 0, 8'h00, 1'b1, 8'h00, got, busy);
    model_apply(1'b1, 1'b0, 8'h30, '0, exp);
    chk("abort_read30_data", got, D30);

    // Back-to-back reads, second raised during DONE
    run_access("b2b_a", 1'b1, 1'b0, 8'h00, '0, 0, 8'h00, 1'b0, 8'hFF, got, busy);
    model_apply(1'b1, 1'b0, 8'h00, '0, exp);
    chk("b2b_a_data", got, D00);
    chk("b2b_a_busy_cycles", 128'(busy), 128'(LAT + 1));
    run_access("b2b_b", 1'b1, 1'b0, 8'hFF, '0, 0, 8'h00, 1'b1, 8'h00, got, busy);
    model_apply(1'b1, 1'b0, 8'hFF, '0, exp);
    chk("b2b_b_data", got, DFF);
    chk("b2b_b_busy_cycles", 128'(busy), 128'(LAT + 1));

    // Random traffic against the model
    for (int k = 0; k < 30; k++) begin
      op = int'($urandom_range(0, 2));
      rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      a = 8'($urandom_range(0, 255));
      if (op == 1) begin
        tries = 0;
        while (!vld[a] && tries < 1000) begin
          a = 8'($urandom_range(0, 255));
          tries++;
        end
        if (!vld[a]) a = 8'h12;
      end
      run_access($sformatf("rnd%0d", k), op != 0, op != 1, a, rdata, 0, 8'h00, 1'b1, 8'h00,
                 got, busy);
      model_apply(op != 0, op != 1, a, rdata, exp);
      chk($sformatf("rnd%0d_data", k), got, exp);
      chk($sformatf("rnd%0d_busy_cycles", k), 128'(busy), 128'(LAT + 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
